gates_sweep: RTL
================

Name: gates_sweep

Overview:
Parametrised successor to the two-input gate demo block. Computes AND/OR/NAND/NOR/XOR/XNOR bitwise over WIDTH-bit operands and drives registered results onto LEDR. Operands come either from switches (manual mode) or from an internal sequencer. The sequencer steps through every {A,B} combination with a programmable dwell, so the truth table plays out on the board without a bench. Sits directly under the board top-level, between switch/key inputs and the LEDs.

Parameters:
WIDTH, 1, operand width in bits; legal 1..8
STEP_CYCLES, 50000000, clock cycles each sweep pattern is held; legal >= 1

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
RST  in  1  asynchronous active-high reset
A  in  WIDTH  manual operand A (switches)
B  in  WIDTH  manual operand B (switches)
MODE  in  1  0 = manual, 1 = sweep enabled
START  in  1  level, sampled each cycle; begins/restarts a sweep when MODE=1
LEDR  out  6*WIDTH  registered results; slice k = LEDR[k*WIDTH +: WIDTH], k: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR
A_CUR  out  WIDTH  operand A currently applied
B_CUR  out  WIDTH  operand B currently applied
BUSY  out  1  high while in RUN
DONE_P  out  1  one-cycle pulse at sweep completion

Behaviour:
- Reset: clock is CLOCK_50; reset is asynchronous and active-high on RST. While RST is high: state=IDLE, LEDR=0, A_CUR=0, B_CUR=0, BUSY=0, DONE_P=0, combo=0, dwell=0. RST asserted mid-sweep aborts immediately.
- Datapath: A_CUR/B_CUR are registers. LEDR is registered from A_CUR/B_CUR, so LEDR lags operand registers by exactly 1 cycle.
- Sweep counter:
  - combo is 2*WIDTH bits; {A_CUR,B_CUR}=combo, with A in the MSBs.
  - Order for WIDTH=1: 00, 01, 10, 11.
  - dwell counts 0..STEP_CYCLES-1; its width is max(1,$clog2(STEP_CYCLES)).
- FSM states: IDLE, MANUAL, RUN, DONE.
  - IDLE:
    - MODE=0 -> MANUAL.
    - MODE=1 & START -> RUN.
    - Otherwise hold.
  - MANUAL:
    - A_CUR<=A, B_CUR<=B every cycle.
    - MODE=1 & START -> RUN.
    - MODE=1 & !START -> IDLE, operands held.
  - RUN (BUSY=1):
    - Entry sets combo=0, dwell=0, operands=0.
    - Each cycle dwell++. At dwell=STEP_CYCLES-1: dwell<=0, combo++, operands<=combo+1.
    - At dwell terminal with combo=all-ones -> DONE, DONE_P=1 for that single cycle; last pattern stays applied.
  - DONE:
    - Operands and LEDR hold the final pattern.
    - MODE=1 & START -> RUN (fresh sweep).
    - MODE=0 -> MANUAL.
- Simultaneous events and priority, highest first: RST > MODE=0 (abort to MANUAL next cycle, BUSY drops) > START (restart from combo=0, dwell=0) > dwell/combo advance.
  - START held high continuously in RUN restarts every cycle. Board logic must pulse START.
  - START asserted in the same cycle as the final terminal count: the restart wins, and DONE_P stays 0.
- STEP_CYCLES=1: combo advances every cycle. A full sweep is 2^(2*WIDTH) cycles in RUN.
- No combinational path from any input to any output.

Optional Feature:
GATES_SWEEP_LOOP_EN:
- Defined: at the final terminal count, combo wraps to 0 and RUN continues. DONE_P pulses once per wrap. DONE is never entered.
- Undefined: single-shot sweep ending in DONE, as described above.

Decomposition:
- gates_pkg:
  - State encoding localparams: IDLE=2'd0, MANUAL=2'd1, RUN=2'd2, DONE=2'd3.
  - Op slice indices: OP_AND..OP_XNOR = 0..5.
  - NUM_OPS=6.
- Sub-module gates_array #(WIDTH): purely combinational. Inputs a, b; output y[6*WIDTH], the six bitwise ops packed by the op indices.
- gates_sweep instantiates gates_array once, registers its output into LEDR, and holds the FSM plus counters.

Test Plan:
1. WIDTH=1: pulse RST mid-cycle -> all outputs 0 asynchronously. Release, MODE=0, A=1, B=0 -> after 2 cycles LEDR=6'b010_110 (AND0 OR1 NAND1 NOR0 XOR1 XNOR0, bit0=AND).
2. WIDTH=1, STEP_CYCLES=4, MODE=1, 1-cycle START -> {A_CUR,B_CUR} = 00,01,10,11 for 4 cycles each, BUSY=1 for 16 cycles, then DONE_P one pulse, final LEDR = AND1 OR1 NAND0 NOR0 XOR0 XNOR1 held.
3. WIDTH=2, STEP_CYCLES=1 -> 16 consecutive combos 0..15. LEDR checked against a reference model every cycle with 1-cycle lag. DONE_P on cycle 16.
4. Mid-sweep (combo=2) drop MODE -> next cycle MANUAL, BUSY=0, A_CUR/B_CUR follow switches, no DONE_P.
5. Mid-sweep START pulse at combo=3 -> combo/dwell restart at 0. START coincident with the final terminal count -> restart, DONE_P stays 0.
6. Build with GATES_SWEEP_LOOP_EN, WIDTH=1, STEP_CYCLES=2 -> combo wraps 3->0, DONE_P pulses every 8 cycles, BUSY stays 1.

Source files
------------

// File: rtl/gates_pkg.sv
// Shared definitions for the gate sweep block: FSM states, op slice indices and dwell sizing.
package gates_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int OP_AND  = 0;
  localparam int OP_OR   = 1;
  localparam int OP_NAND = 2;
  localparam int OP_NOR  = 3;
  localparam int OP_XOR  = 4;
  localparam int OP_XNOR = 5;
  localparam int NUM_OPS = 6;

  // A dwell of one cycle still needs a one-bit counter to keep the port widths legal.
  function automatic int dwell_width(input int step_cycles);
    return (step_cycles > 1) ? $clog2(step_cycles) : 1;
  endfunction

endpackage

// File: rtl/gates_array.sv
// Purely combinational bank of the six bitwise gates, packed by op index.
module gates_array
  import gates_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic [NUM_OPS*WIDTH-1:0] y
);

  assign y[OP_AND*WIDTH  +: WIDTH] = a & b;
  assign y[OP_OR*WIDTH   +: WIDTH] = a | b;
  assign y[OP_NAND*WIDTH +: WIDTH] = ~(a & b);
  assign y[OP_NOR*WIDTH  +: WIDTH] = ~(a | b);
  assign y[OP_XOR*WIDTH  +: WIDTH] = a ^ b;
  assign y[OP_XNOR*WIDTH +: WIDTH] = ~(a ^ b);

endmodule

// File: rtl/gates_sweep.sv
// Gate demo with manual operands or an automatic truth-table sweep; results registered onto LEDR.
// Define GATES_SWEEP_LOOP_EN to make the sweep wrap and run forever instead of stopping in DONE.
module gates_sweep
  import gates_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int STEP_CYCLES = 50000000
) (
  input  logic                     CLOCK_50,
  input  logic                     RST,
  input  logic [WIDTH-1:0]         A,
  input  logic [WIDTH-1:0]         B,
  input  logic                     MODE,
  input  logic                     START,
  output logic [NUM_OPS*WIDTH-1:0] LEDR,
  output logic [WIDTH-1:0]         A_CUR,
  output logic [WIDTH-1:0]         B_CUR,
  output logic                     BUSY,
  output logic                     DONE_P
);

  localparam int CW = 2 * WIDTH;
  localparam int DW = dwell_width(STEP_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] COMBO_LAST = '1;

  state_t            state;
  logic [CW-1:0]     combo;
  logic [CW-1:0]     combo_inc;
  logic [DW-1:0]     dwell;
  logic [NUM_OPS*WIDTH-1:0] gate_y;

  assign combo_inc = combo + CW'(1);

  gates_array #(.WIDTH(WIDTH)) u_gates (
    .a (A_CUR),
    .b (B_CUR),
    .y (gate_y)
  );

  // Priority: MODE=0 aborts to manual, then START restarts, then the dwell/combo advance.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      combo  <= '0;
      dwell  <= '0;
      A_CUR  <= '0;
      B_CUR  <= '0;
      BUSY   <= 1'b0;
      DONE_P <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values; the default
      // below makes DONE_P a single-cycle pulse unless a terminal count re-asserts it.
      DONE_P <= 1'b0;
      if (!MODE) begin
        state <= MANUAL;
        BUSY  <= 1'b0;
        A_CUR <= A;
        B_CUR <= B;
      end else if (START) begin
        state <= RUN;
        BUSY  <= 1'b1;
        combo <= '0;
        dwell <= '0;
        A_CUR <= '0;
        B_CUR <= '0;
      end else begin
        case (state)
          MANUAL: state <= IDLE;
          RUN: begin
            if (dwell == DWELL_LAST) begin
              dwell <= '0;
              if (combo == COMBO_LAST) begin
                DONE_P <= 1'b1;
`ifdef GATES_SWEEP_LOOP_EN
                combo          <= '0;
                {A_CUR, B_CUR} <= '0;
`else
                state <= DONE;
                BUSY  <= 1'b0;
`endif
              end else begin
                combo          <= combo_inc;
                {A_CUR, B_CUR} <= combo_inc;
              end
            end else begin
              dwell <= dwell + DW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) LEDR <= '0;
    else     LEDR <= gate_y;
  end

endmodule
